comparador_serial: RTL and testbench
====================================

// Module: comparador_serial
// PURPOSE
//   Sequential, parametrised magnitude comparator for two N-bit words.
//   Operands are latched on a start request and scanned one bit per clock.
//   Scan runs left-to-right (MSB->LSB, early exit) or right-to-left (LSB->MSB, full scan).
//   Produces registered gt/eq/lt flags, a one-cycle done pulse and a bit count.
//   Used by the traversal datapath wherever a multi-cycle, low-gate compare is acceptable.
// PARAMETERS
//   N       8  operand width in bits (N >= 2)
//   SIGNED  0  0 = unsigned compare; 1 = two's-complement compare (sense of bit N-1 inverted)
// PORTS
//   clk       in   1                 single clock; all state on rising edge
//   reset_L   in   1                 asynchronous, active-low reset
//   start     in   1                 request; sampled only in IDLE
//   modo      in   1                 0 = left-to-right (MSB first); 1 = right-to-left (LSB first)
//   wordA     in   N                 operand A; sampled with start
//   wordB     in   N                 operand B; sampled with start
//   busy      out  1                 high in SCAN and DONE
//   done      out  1                 one-cycle pulse; result valid from this cycle on
//   gt        out  1                 A > B
//   eq        out  1                 A == B
//   lt        out  1                 A < B
//   bits_cmp  out  $clog2(N+1)       number of bit positions examined in the last operation
// BEHAVIOUR
//   - Reset (reset_L=0, async): state=IDLE; busy=done=gt=eq=lt=0; bits_cmp=0. Internal regs cleared.
//   - Reset mid-operation aborts the scan with no partial result; the first start after release is served normally.
//   - States: IDLE, SCAN, DONE. All outputs are registered.
//   - IDLE:
//       - start=1 latches wordA, wordB and modo into internal regs and moves to SCAN.
//       - idx is set to N-1 (modo=0) or 0 (modo=1); the internal result is set to EQ; bits_cmp=0.
//       - gt/eq/lt keep the previous result until the next done.
//   - SCAN, one bit per cycle at position idx:
//       - Bit ordering: ua=a[idx], ub=b[idx]. With SIGNED=1 and idx==N-1, a>b at that bit means A<B.
//       - Each SCAN cycle increments bits_cmp.
//       - modo=0: first differing bit decides the result and moves to DONE at once. If bits are equal and idx==0, result=EQ and go to DONE; otherwise idx--.
//       - modo=1: a differing bit overwrites the result with that bit's verdict; equal bits leave it unchanged. At idx==N-1 go to DONE; otherwise idx++. Always N cycles; the last differing bit wins.
//   - DONE: done=1 for exactly one cycle; gt/eq/lt are loaded, exactly one of them is high; next state is IDLE.
//   - Latency, counting the start-accept edge as edge 0, with p = index of the most significant differing bit:
//       - modo=0: done is high in the cycle after edge N-p; bits_cmp = N-p.
//       - modo=1, or equal operands in either mode: done is high in the cycle after edge N; bits_cmp = N.
//   - start while busy (SCAN or DONE) is ignored: no re-latch, no queueing.
//   - wordA/wordB/modo changes during SCAN have no effect (latched copies are used).
//   - Back-to-back throughput: a new start is accepted earliest in the cycle after done.
// TESTING
//   1 N=8, modo=0, A=0xA5, B=0xA3 -> gt=1, eq=lt=0, done after edge 6, bits_cmp=6.
//   2 Same operands, modo=1 -> gt=1, done after edge 8, bits_cmp=8; then A=0x3C, B=0x3C in both modes -> eq=1 at edge 8.
//   3 SIGNED=1, modo=0, A=0x80, B=0x01 -> lt=1 at edge 1, bits_cmp=1; with SIGNED=0 -> gt=1 at edge 1.
//   4 modo=1, A=0x01, B=0x80 (unsigned) -> early LSB verdict gt is overwritten by bit 7 -> lt=1 at edge 8.
//   5 Pulse start again at edges 2-4 of a scan with different operands -> ignored; original result and timing unchanged.
//   6 reset_L low at edge 3 of a scan -> all outputs 0 immediately; after release, start A=0x10, B=0x20, modo=0 -> lt=1, bits_cmp=3.

Source files
------------

// File: rtl/comparador_serial.sv
// comparador_serial
//   Multi-cycle magnitude comparator for two N-bit words. A start request
//   latches both operands and the scan direction. After that the comparator
//   examines one bit per clock cycle:
//     - modo=0 scans MSB->LSB and stops at the first differing bit.
//     - modo=1 scans LSB->MSB over all N bits; the last differing bit wins.
//   The gt/eq/lt flags are loaded together with a one-cycle done pulse. They
//   then hold their value until the next done.
//
// Parameters
//   N        operand width in bits (N >= 2)
//   SIGNED   0 = unsigned compare, 1 = two's-complement compare
//
// Ports
//   clk       clock; all state changes on the rising edge
//   reset_L   asynchronous active-low reset
//   start     request; sampled only while idle
//   modo      scan direction (0 = MSB first, 1 = LSB first); sampled with start
//   wordA     operand A; sampled with start
//   wordB     operand B; sampled with start
//   busy      high while scanning and during the done cycle
//   done      one-cycle pulse when the result is loaded
//   gt/eq/lt  result of the last operation (exactly one high after the first done)
//   bits_cmp  number of bit positions examined in the last operation
module comparador_serial #(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     start,
  input  logic                     modo,
  input  logic [N-1:0]             wordA,
  input  logic [N-1:0]             wordB,
  output logic                     busy,
  output logic                     done,
  output logic                     gt,
  output logic                     eq,
  output logic                     lt,
  output logic [$clog2(N+1)-1:0]   bits_cmp
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);
  localparam logic [IW-1:0] IDX_MSB = IW'(N-1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {RES_EQ = 2'd0, RES_GT = 2'd1, RES_LT = 2'd2} res_t;

  state_t          state, nxt_state;
  res_t            res, nxt_res, fin_res, bit_res;
  logic [N-1:0]    a_lat, b_lat, nxt_a, nxt_b;
  logic            modo_lat, nxt_modo;
  logic [IW-1:0]   idx, nxt_idx;
  logic [CW-1:0]   nxt_bits;
  logic            nxt_busy, nxt_done, nxt_gt, nxt_eq, nxt_lt;
  logic            finish;
  logic            bit_a, bit_b, differ, sign_pos, a_wins;

  // Verdict of the bit currently under scan. In a signed compare the sign bit
  // has inverted weight: A having a 1 there makes A the smaller value.
  always_comb begin
    bit_a    = a_lat[idx];
    bit_b    = b_lat[idx];
    differ   = bit_a ^ bit_b;
    sign_pos = (SIGNED != 1'b0) && (idx == IDX_MSB);
    a_wins   = bit_a ^ sign_pos;
    if (differ) begin
      bit_res = a_wins ? RES_GT : RES_LT;
    end else begin
      bit_res = RES_EQ;
    end
  end

  // Next-state and next-output logic for the IDLE/SCAN/DONE sequencer.
  always_comb begin
    nxt_state = state;
    nxt_res   = res;
    nxt_a     = a_lat;
    nxt_b     = b_lat;
    nxt_modo  = modo_lat;
    nxt_idx   = idx;
    nxt_bits  = bits_cmp;
    nxt_busy  = busy;
    nxt_done  = 1'b0;
    finish    = 1'b0;
    fin_res   = res;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = SCAN;
          nxt_a     = wordA;
          nxt_b     = wordB;
          nxt_modo  = modo;
          nxt_idx   = modo ? {IW{1'b0}} : IDX_MSB;
          nxt_res   = RES_EQ;
          nxt_bits  = {CW{1'b0}};
          nxt_busy  = 1'b1;
        end else begin
          nxt_state = IDLE;
        end
      end
      SCAN: begin
        nxt_bits = bits_cmp + CW'(1'b1);
        if (!modo_lat) begin
          // MSB first: the first differing bit settles the compare.
          if (differ) begin
            finish  = 1'b1;
            fin_res = bit_res;
          end else if (idx == {IW{1'b0}}) begin
            finish  = 1'b1;
            fin_res = RES_EQ;
          end else begin
            nxt_idx = idx - IW'(1'b1);
          end
        end else begin
          // LSB first: every differing bit overrides the previous verdict,
          // so the most significant difference has the final say.
          if (differ) begin
            nxt_res = bit_res;
            fin_res = bit_res;
          end else begin
            fin_res = res;
          end
          if (idx == IDX_MSB) begin
            finish = 1'b1;
          end else begin
            nxt_idx = idx + IW'(1'b1);
          end
        end
        if (finish) begin
          nxt_state = DONE;
          nxt_done  = 1'b1;
        end else begin
          nxt_state = SCAN;
        end
      end
      DONE: begin
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
      end
    endcase

    if (finish) begin
      nxt_gt = (fin_res == RES_GT);
      nxt_eq = (fin_res == RES_EQ);
      nxt_lt = (fin_res == RES_LT);
    end else begin
      nxt_gt = gt;
      nxt_eq = eq;
      nxt_lt = lt;
    end
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      res      <= RES_EQ;
      a_lat    <= {N{1'b0}};
      b_lat    <= {N{1'b0}};
      modo_lat <= 1'b0;
      idx      <= {IW{1'b0}};
      bits_cmp <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
    end else begin
      state    <= nxt_state;
      res      <= nxt_res;
      a_lat    <= nxt_a;
      b_lat    <= nxt_b;
      modo_lat <= nxt_modo;
      idx      <= nxt_idx;
      bits_cmp <= nxt_bits;
      busy     <= nxt_busy;
      done     <= nxt_done;
      gt       <= nxt_gt;
      eq       <= nxt_eq;
      lt       <= nxt_lt;
    end
  end

endmodule

// File: tb/tb_comparador_serial.sv
// Bench for comparador_serial (N=8). An unsigned and a signed instance share
// the same stimulus. Expected flags come from plain integer compares.
// Expected latency comes from the position of the top differing bit.
module tb_comparador_serial;

  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          start = 1'b0;
  logic          modo = 1'b0;
  logic [N-1:0]  wordA = '0;
  logic [N-1:0]  wordB = '0;
  logic          busy_u, done_u, gt_u, eq_u, lt_u;
  logic          busy_s, done_s, gt_s, eq_s, lt_s;
  logic [CW-1:0] bits_u, bits_s;

  int checks = 0;
  int errors = 0;
  logic [2:0] held_u = 3'b000;
  logic [2:0] held_s = 3'b000;

  comparador_serial #(.N(N), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset_L(reset_L), .start(start), .modo(modo),
    .wordA(wordA), .wordB(wordB), .busy(busy_u), .done(done_u),
    .gt(gt_u), .eq(eq_u), .lt(lt_u), .bits_cmp(bits_u));

  comparador_serial #(.N(N), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset_L(reset_L), .start(start), .modo(modo),
    .wordA(wordA), .wordB(wordB), .busy(busy_s), .done(done_s),
    .gt(gt_s), .eq(eq_s), .lt(lt_s), .bits_cmp(bits_s));

  always #5 clk = ~clk;

  // Reference compare: 0 = equal, 1 = A greater, 2 = A smaller.
  function automatic int ref_cmp(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn);
    int sa, sb;
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    if (sa > sb) return 1;
    else if (sa < sb) return 2;
    else return 0;
  endfunction

  // Reference latency = number of bits examined.
  function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
    if (m || a == b) return N;
    for (int i = N-1; i >= 0; i--) begin
      if (a[i] != b[i]) return N - i;
    end
    return N;
  endfunction

  function automatic logic [2:0] flags_of(input int code);
    return {code == 1, code == 0, code == 2};
  endfunction

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic m, input string name);
    wordA = a; wordB = b; modo = m; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy_u, done_u, busy_s, done_s} !== 4'b1010) begin
      errors++;
      $display("FAIL %s accept: busy/done u=%b%b s=%b%b required 10 10", name, busy_u, done_u, busy_s, done_s);
    end
  endtask

  task automatic wait_result(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                             input bit glitch, input string name);
    int cu, cs, lat, k_seen;
    bit found;
    logic [8:0] obs, expv;
    cu = ref_cmp(a, b, 1'b0);
    cs = ref_cmp(a, b, 1'b1);
    lat = ref_lat(a, b, m);
    found = 1'b0;
    k_seen = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_u || done_s) begin
        found = 1'b1;
        k_seen = k;
      end else begin
        // Inputs wander during the scan; only the latched copies matter.
        wordA = N'($urandom);
        wordB = N'($urandom);
        modo  = 1'($urandom);
        start = glitch && (k <= 3);
      end
    end
    start = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 edges, required done after edge %0d", name, lat);
    end else if (k_seen != lat) begin
      errors++;
      $display("FAIL %s latency: done after edge %0d, required %0d", name, k_seen, lat);
    end
    if (found) begin
      held_u = flags_of(cu);
      held_s = flags_of(cs);
      obs  = {done_u, busy_u, gt_u, eq_u, lt_u, bits_u};
      expv = {2'b11, held_u, CW'(lat)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s unsigned result: done,busy,gt,eq,lt,bits=%b required %b", name, obs, expv);
      end
      obs  = {done_s, busy_s, gt_s, eq_s, lt_s, bits_s};
      expv = {2'b11, held_s, CW'(lat)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s signed result: done,busy,gt,eq,lt,bits=%b required %b", name, obs, expv);
      end
    end
  endtask

  task automatic tail(input string name);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({done_u, busy_u, gt_u, eq_u, lt_u, done_s, busy_s, gt_s, eq_s, lt_s} !==
        {2'b00, held_u, 2'b00, held_s}) begin
      errors++;
      $display("FAIL %s after done: u=%b%b%b%b%b s=%b%b%b%b%b required 00%b 00%b", name,
               done_u, busy_u, gt_u, eq_u, lt_u, done_s, busy_s, gt_s, eq_s, lt_s, held_u, held_s);
    end
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m, input string name);
    launch(a, b, m, name);
    wait_result(a, b, m, 1'b0, name);
    tail(name);
  endtask

  task automatic test_reset;
    reset_L = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy_u, done_u, gt_u, eq_u, lt_u, bits_u, busy_s, done_s, gt_s, eq_s, lt_s, bits_s} !== '0) begin
      errors++;
      $display("FAIL reset: u=%b%b%b%b%b bits=%0d s=%b%b%b%b%b bits=%0d required all 0",
               busy_u, done_u, gt_u, eq_u, lt_u, bits_u, busy_s, done_s, gt_s, eq_s, lt_s, bits_s);
    end
    reset_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    do_op(8'hA5, 8'hA3, 1'b0, "msb_first_gt");
    do_op(8'hA5, 8'hA3, 1'b1, "lsb_first_gt");
    do_op(8'h3C, 8'h3C, 1'b0, "eq_msb_first");
    do_op(8'h3C, 8'h3C, 1'b1, "eq_lsb_first");
    do_op(8'h80, 8'h01, 1'b0, "sign_bit");
    do_op(8'h01, 8'h80, 1'b1, "lsb_overwrite");
    do_op(8'h00, 8'hFF, 1'b0, "extreme");
  endtask

  task automatic test_ignored_start;
    launch(8'hA5, 8'hA3, 1'b0, "start_while_busy");
    wait_result(8'hA5, 8'hA3, 1'b0, 1'b1, "start_while_busy");
    tail("start_while_busy");
  endtask

  task automatic test_reset_mid;
    launch(8'hA5, 8'hA3, 1'b1, "reset_mid");
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 reset_L = 1'b0;
    #1;
    checks++;
    if ({busy_u, done_u, gt_u, eq_u, lt_u, bits_u, busy_s, done_s, gt_s, eq_s, lt_s, bits_s} !== '0) begin
      errors++;
      $display("FAIL reset_mid: u=%b%b%b%b%b s=%b%b%b%b%b required all 0",
               busy_u, done_u, gt_u, eq_u, lt_u, busy_s, done_s, gt_s, eq_s, lt_s);
    end
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
    do_op(8'h10, 8'h20, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    launch(8'hA5, 8'hA3, 1'b1, "b2b_first");
    wait_result(8'hA5, 8'hA3, 1'b1, 1'b0, "b2b_first");
    // Start raised in the done cycle: ignored at that edge, taken one edge later.
    wordA = 8'h12; wordB = 8'h34; modo = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_u, done_u, busy_s, done_s} !== 4'b0000) begin
      errors++;
      $display("FAIL b2b idle gap: busy/done u=%b%b s=%b%b required 00 00", busy_u, done_u, busy_s, done_s);
    end
    launch(8'h12, 8'h34, 1'b0, "b2b_second");
    wait_result(8'h12, 8'h34, 1'b0, 1'b0, "b2b_second");
    tail("b2b_second");
  endtask

  task automatic test_random;
    logic [N-1:0] a, b;
    logic m;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (N'(1) << $urandom_range(0, N-1));
        default: b = N'($urandom);
      endcase
      m = 1'($urandom);
      do_op(a, b, m, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
